// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and the colour codes
// shared between the sync generator and the pattern generators.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] CYAN  = 3'b011;
    localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/vga_sync_gen_pix_tick_div.sv
// Divides the system clock down to a one-clk pixel strobe.
// A divide of 1 leaves the strobe permanently high.
module pix_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("pix_tick_div: CLK_DIV must be >= 1");
        end
    endgenerate

    assign tick_o = (div_cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt <= '0;
        end else if (tick_o) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters plus a one-pixel output stage that keeps
// blanked colour and both syncs aligned for the DAC.
module vga_sync_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int SYNC_POL = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       pix_tick_o,
    output logic [9:0] column_o,
    output logic [9:0] row_o,
    output logic       video_on_o,
    output logic       frame_start_o,
    input  logic [2:0] rgb_i,
    output logic [2:0] rgb_o,
    output logic       hsync_o,
    output logic       vsync_o
);

    import vga_timing_pkg::*;

    localparam int H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_LEN - 1);
    localparam logic [9:0] V_LAST = 10'(V_LEN - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON = (SYNC_POL != 0);

    generate
        if (CLK_DIV < 1 || H_LEN > 1023 || V_LEN > 1023) begin : g_bad_cfg
            $error("vga_sync_gen: illegal timing parameters");
        end
    endgenerate

    logic       tick;
    logic [9:0] column;
    logic [9:0] row;
    logic       h_sync_on;
    logic       v_sync_on;
    logic       video_on;

    pix_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    assign video_on  = (column < H_VIS) && (row < V_VIS);
    assign h_sync_on = (column >= HS_BEG) && (column <= HS_END);
    assign v_sync_on = (row >= VS_BEG) && (row <= VS_END);

    assign pix_tick_o    = tick;
    assign column_o      = column;
    assign row_o         = row;
    assign video_on_o    = video_on;
    assign frame_start_o = tick && (column == '0) && (row == '0);

    // Outputs sample the pixel the counters show now, so they
    // trail the counters by exactly one pixel period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            column  <= '0;
            row     <= '0;
            rgb_o   <= BLACK;
            hsync_o <= ~SYNC_ON;
            vsync_o <= ~SYNC_ON;
        end else if (tick) begin
            rgb_o   <= video_on ? rgb_i : BLACK;
            hsync_o <= h_sync_on ? SYNC_ON : ~SYNC_ON;
            vsync_o <= v_sync_on ? SYNC_ON : ~SYNC_ON;
            if (column == H_LAST) begin
                column <= '0;
                row    <= (row == V_LAST) ? '0 : row + 1'b1;
            end else begin
                column <= column + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: default, fast/positive-sync
// and shrunken-timing instances, exercised one at a time.
module tb_vga_sync_gen;

    import vga_timing_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst = 3'b111;
    logic       mode = 1'b0;

    logic       tick [3];
    logic [9:0] col  [3];
    logic [9:0] row  [3];
    logic       von  [3];
    logic       fs   [3];
    logic [2:0] rin  [3];
    logic [2:0] rgb  [3];
    logic       hs   [3];
    logic       vs   [3];

    int p_div [3] = '{2, 1, 3};
    int p_ha  [3] = '{H_ACTIVE, H_ACTIVE, 16};
    int p_hf  [3] = '{H_FP, H_FP, 2};
    int p_hs  [3] = '{H_SYNC, H_SYNC, 3};
    int p_hb  [3] = '{H_BP, H_BP, 2};
    int p_va  [3] = '{V_ACTIVE, V_ACTIVE, 12};
    int p_vf  [3] = '{V_FP, V_FP, 2};
    int p_vs  [3] = '{V_SYNC, V_SYNC, 2};
    int p_vb  [3] = '{V_BP, V_BP, 3};
    int p_pol [3] = '{0, 1, 0};

    function automatic logic [2:0] pat(input int c, input int r);
        return mode ? 3'(c ^ r) : RED;
    endfunction

    // Pattern generator stand-in: combinational from each DUT's counters.
    assign rin[0] = pat(int'(col[0]), int'(row[0]));
    assign rin[1] = pat(int'(col[1]), int'(row[1]));
    assign rin[2] = pat(int'(col[2]), int'(row[2]));

    vga_sync_gen u_dflt (
        .clk_i(clk), .rst_i(rst[0]), .pix_tick_o(tick[0]),
        .column_o(col[0]), .row_o(row[0]), .video_on_o(von[0]),
        .frame_start_o(fs[0]), .rgb_i(rin[0]), .rgb_o(rgb[0]),
        .hsync_o(hs[0]), .vsync_o(vs[0])
    );

    vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1)) u_fast (
        .clk_i(clk), .rst_i(rst[1]), .pix_tick_o(tick[1]),
        .column_o(col[1]), .row_o(row[1]), .video_on_o(von[1]),
        .frame_start_o(fs[1]), .rgb_i(rin[1]), .rgb_o(rgb[1]),
        .hsync_o(hs[1]), .vsync_o(vs[1])
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0)
    ) u_small (
        .clk_i(clk), .rst_i(rst[2]), .pix_tick_o(tick[2]),
        .column_o(col[2]), .row_o(row[2]), .video_on_o(von[2]),
        .frame_start_o(fs[2]), .rgb_i(rin[2]), .rgb_o(rgb[2]),
        .hsync_o(hs[2]), .vsync_o(vs[2])
    );

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t sb [$];
    exp_t e_cur;

    int k = 0;
    int checks = 0;
    int errors = 0;
    int m_div, m_col, m_row;
    bit line_seen, frame_seen;
    int l_ticks, l_hs, f_ticks, f_vs;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t",
                     tag, k, got, want, $time);
        end
    endtask

    // One clk: compare at the falling edge, push the pixel's expected
    // output, then pop it once the rising edge has registered it.
    task automatic step();
        int   ht, vt;
        logic t, pol;
        exp_t e;
        ht  = p_ha[k] + p_hf[k] + p_hs[k] + p_hb[k];
        vt  = p_va[k] + p_vf[k] + p_vs[k] + p_vb[k];
        pol = (p_pol[k] != 0);
        t   = (m_div == p_div[k] - 1);
        check("tick", tick[k], t);
        check("column", col[k], m_col);
        check("row", row[k], m_row);
        check("video_on", von[k], (m_col < p_ha[k]) && (m_row < p_va[k]));
        check("frame_start", fs[k], t && m_col == 0 && m_row == 0);
        check("rgb", rgb[k], e_cur.rgb);
        check("hsync", hs[k], e_cur.hs);
        check("vsync", vs[k], e_cur.vs);
        if (tick[k]) begin
            if (col[k] == 0) begin
                if (line_seen) begin
                    check("line_ticks", l_ticks, ht);
                    check("hsync_len", l_hs, p_hs[k]);
                end
                line_seen = 1'b1;
                l_ticks = 0;
                l_hs = 0;
            end
            if (fs[k]) begin
                if (frame_seen) begin
                    check("frame_ticks", f_ticks, ht * vt);
                    check("vsync_len", f_vs, p_vs[k] * ht);
                end
                frame_seen = 1'b1;
                f_ticks = 0;
                f_vs = 0;
            end
            l_ticks++;
            f_ticks++;
            if (hs[k] == pol) l_hs++;
            if (vs[k] == pol) f_vs++;
        end
        if (t) begin
            e.rgb = (m_col < p_ha[k] && m_row < p_va[k]) ?
                    pat(m_col, m_row) : BLACK;
            e.hs = (m_col >= p_ha[k] + p_hf[k] &&
                    m_col < p_ha[k] + p_hf[k] + p_hs[k]) ? pol : ~pol;
            e.vs = (m_row >= p_va[k] + p_vf[k] &&
                    m_row < p_va[k] + p_vf[k] + p_vs[k]) ? pol : ~pol;
            sb.push_back(e);
        end
        @(posedge clk);
        if (sb.size() > 0) e_cur = sb.pop_front();
        if (t) begin
            m_div = 0;
            if (m_col == ht - 1) begin
                m_col = 0;
                m_row = (m_row == vt - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end else begin
            m_div++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        logic pol;
        pol = (p_pol[k] != 0);
        rst[k] = 1'b1;
        repeat (n) @(negedge clk);
        m_div = 0;
        m_col = 0;
        m_row = 0;
        sb.delete();
        e_cur = '{rgb: BLACK, hs: ~pol, vs: ~pol};
        line_seen = 1'b0;
        frame_seen = 1'b0;
        rst[k] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        @(negedge clk);

        // Default timing: reset, two full lines of blanking, mid-line reset.
        k = 0;
        mode = 1'b0;
        do_reset(3);
        run(2 * 800 * 2);
        mode = 1'b1;
        for (int i = 0; i < 2000 && !(m_row == 2 && m_col == 300); i++)
            step();
        check("reach_mid", {row[0], col[0]}, {10'd2, 10'd300});
        do_reset(1);
        run(400);
        rst[0] = 1'b1;

        // One pixel per clk with active-high syncs.
        k = 1;
        do_reset(2);
        run(1700);
        rst[1] = 1'b1;

        // Shrunken raster so frame wrap and vsync fit in a short run.
        k = 2;
        mode = 1'b0;
        do_reset(2);
        run(3 * 23 * 19 * 3 + 60);
        rst[2] = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 timing from a system clock divided down to the pixel rate.
- Drives row/column coordinates into the pattern generators (e.g. pattgen1) and takes back their combinational 3-bit colour.
- Registers that colour, blanks it outside the active area, and aligns it with hsync/vsync for the DAC/pins stage.

Parameters:
- CLK_DIV, 2: system clocks per pixel (50 MHz -> 25 MHz); legal range >= 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync active level (0 = active-low).

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: synchronous, active-high reset.
- pix_tick_o, output, 1: one-clk pulse per pixel period.
- column_o, output, 10: horizontal counter, 0..H_TOTAL-1.
- row_o, output, 10: vertical counter, 0..V_TOTAL-1.
- video_on_o, output, 1: high when column_o < H_ACTIVE and row_o < V_ACTIVE (combinational decode of the counters).
- frame_start_o, output, 1: one-clk pulse at pixel (0,0).
- rgb_i, input, 3: colour from the pattern generator for the current row_o/column_o.
- rgb_o, output, 3: registered, blanked colour.
- hsync_o, output, 1: registered horizontal sync, aligned with rgb_o.
- vsync_o, output, 1: registered vertical sync, aligned with rgb_o.

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Counters are 10-bit unsigned; defaults fit.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick_o = (div_cnt == CLK_DIV-1), combinational.
  - With CLK_DIV = 1, pix_tick_o is constantly 1 out of reset.
- Counters advance only on clk edges where pix_tick_o = 1:
  - column wraps from H_TOTAL-1 to 0; on that wrap row increments.
  - row wraps from V_TOTAL-1 to 0, on the same edge column wraps.
  - No other wrap points.
- frame_start_o = pix_tick_o & (column_o == 0) & (row_o == 0).
- Output stage (stage 2), updated on pix_tick_o edges only, otherwise held:
  - rgb_o <= video_on_o ? rgb_i : 3'b000.
  - hsync_o <= SYNC_POL when column_o is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], else ~SYNC_POL.
  - vsync_o <= SYNC_POL when row_o is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], else ~SYNC_POL.
- Latency: rgb_o/hsync_o/vsync_o lag row_o/column_o by exactly one pixel period. The downstream stage sees consistent, aligned colour and sync.
- Reset (rst_i sampled high on a clk edge), all synchronous:
  - div_cnt = 0; column_o = 0; row_o = 0.
  - rgb_o = 3'b000; hsync_o = vsync_o = ~SYNC_POL.
  - pix_tick_o = (CLK_DIV == 1); video_on_o = 1 (decoded from 0,0).
- Reset mid-line or mid-frame: the very next state is the reset state. No partial-line completion; timing restarts from (0,0).
- rgb_i is treated as combinational from row_o/column_o. It is sampled only on tick edges; changes between ticks are ignored.
- Illegal parameter sets (CLK_DIV = 0, or a total > 1023) are excluded by an elaboration-time check.

Decomposition:
- Package vga_timing_pkg:
  - 640x480 timing constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL).
  - Colour constants shared with the pattern generators: RED 3'b100, GREEN 3'b010, BLUE 3'b001, CYAN 3'b011, BLACK 3'b000.
- One sub-module, pix_tick_div (parameter CLK_DIV; ports clk_i, rst_i, tick_o), holds the divider.
- Counters, decode and output stage stay in vga_sync_gen.

Test Plan:
- Reset, CLK_DIV = 2:
  - Hold rst_i for 3 clks, then release.
  - Required: column_o = 0, row_o = 0, rgb_o = 0, hsync_o = vsync_o = 1.
  - pix_tick_o first high on the 2nd clk after release.
- Line timing:
  - Run one full line.
  - Required: exactly 800 ticks per line.
  - hsync_o low for 96 ticks, starting on the tick after column_o = 656.
  - row_o increments on the edge column_o goes 799 -> 0.
- Frame wrap:
  - Run 525 lines.
  - Required: row 524 / column 799 -> (0,0) on a single edge.
  - frame_start_o pulses once per frame, exactly 420000 ticks apart.
  - vsync_o low for 2 lines (rows 490-491, delayed one pixel).
- Blanking:
  - Drive rgb_i = 3'b100 constantly.
  - Required: rgb_o = 3'b100 for columns 0..639 (one tick later); rgb_o = 3'b000 for columns 640..799 and rows 480..524.
- Reset mid-operation:
  - Assert rst_i at row 200, column 300, for 1 clk.
  - Required: next clk shows (0,0), rgb_o = 0, syncs inactive, divider restarted.
- CLK_DIV = 1, SYNC_POL = 1:
  - Run a full line.
  - Required: a tick every clk; line = 800 clks; hsync_o high only during columns 656..751 (+1 delay).
